// File: rtl/ps2_kbd_ascii.sv
// PS/2 keyboard front end: frame receiver, 8-deep scancode FIFO, make/break decoder to ASCII.
// Optional feature macro: KBD_SHIFT_EN (shift keys select uppercase letters).
module ps2_kbd_ascii #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk_i,
  input  logic       clrn_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       dbg_stall_i,  // test hook: holds off decoder pops; tie low in the system
  output logic [1:0] state_o,
  output logic [7:0] kbd_ascii_o,
  output logic [7:0] key_count_o,
  output logic       err_o,
  output logic       overflow_o
);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] CodeBrk = 8'hF0;
  localparam logic [7:0] CodeExt = 8'hE0;

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} dec_st_e;

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    unique case (code)
      8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;  8'h23: return 8'h64;
      8'h24: return 8'h65;  8'h2B: return 8'h66;  8'h34: return 8'h67;  8'h33: return 8'h68;
      8'h43: return 8'h69;  8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
      8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;  8'h4D: return 8'h70;
      8'h15: return 8'h71;  8'h2D: return 8'h72;  8'h1B: return 8'h73;  8'h2C: return 8'h74;
      8'h3C: return 8'h75;  8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
      8'h35: return 8'h79;  8'h1A: return 8'h7A;
      8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;  8'h26: return 8'h33;
      8'h25: return 8'h34;  8'h2E: return 8'h35;  8'h36: return 8'h36;  8'h3D: return 8'h37;
      8'h3E: return 8'h38;  8'h46: return 8'h39;
      8'h29: return 8'h20;  8'h5A: return 8'h0D;
      default: return 8'h00;
    endcase
  endfunction

  // Receiver
  logic [2:0]      clk_sync_q, dat_sync_q;
  logic [10:0]     rx_sr_q, rx_sr_d, frame;
  logic [3:0]      cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            push_q, push_d, err_q, err_d, fall;
  logic [7:0]      rx_byte_q, rx_byte_d;

  assign fall  = clk_sync_q[2] & ~clk_sync_q[1];
  assign frame = {dat_sync_q[1], rx_sr_q[10:1]};

  always_comb begin
    rx_sr_d   = rx_sr_q;
    cnt_d     = cnt_q;
    tmo_d     = '0;
    push_d    = 1'b0;
    rx_byte_d = rx_byte_q;
    err_d     = 1'b0;
    if (fall) begin
      rx_sr_d = frame;
      if (cnt_q == 4'd10) begin
        cnt_d = 4'd0;
        if (!frame[0] && frame[10] && (^frame[9:1])) begin
          push_d    = 1'b1;
          rx_byte_d = frame[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (cnt_q != 4'd0) begin
      if (tmo_q == TmoW'(TIMEOUT - 1)) begin
        cnt_d = 4'd0;
        err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge clrn_ni) begin
    if (!clrn_ni) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 3'b111;
      rx_sr_q    <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      push_q     <= 1'b0;
      rx_byte_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[1:0], ps2_data_i};
      rx_sr_q    <= rx_sr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      push_q     <= push_d;
      rx_byte_q  <= rx_byte_d;
      err_q      <= err_d;
    end
  end

  // FIFO
  logic [7:0] mem_q [8];
  logic [2:0] wr_q, rd_q;
  logic [3:0] fcnt_q;
  logic       ovf_q, pop, full, do_push;
  logic [7:0] pop_byte;

  assign pop      = (fcnt_q != 4'd0) && !dbg_stall_i;
  assign full     = (fcnt_q == 4'd8);
  assign do_push  = push_q && (!full || pop);
  assign pop_byte = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= rx_byte_q;
  end

  always_ff @(posedge clk_i or negedge clrn_ni) begin
    if (!clrn_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_q + 3'(do_push);
      rd_q   <= rd_q + 3'(pop);
      fcnt_q <= fcnt_q + 4'(do_push) - 4'(pop);
      if (push_q && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Decoder
  dec_st_e    dec_st_q, dec_st_d;
  logic [1:0] state_q, state_d;
  logic [7:0] ascii_q, ascii_d, held_q, held_d, count_q, count_d, asc, make_ascii;

  assign asc = scan_to_ascii(pop_byte);

`ifdef KBD_SHIFT_EN
  logic shift_on_q, shift_on_d, is_shift;
  assign is_shift = (pop_byte == 8'h12) || (pop_byte == 8'h59);
`endif

  always_comb begin
    make_ascii = asc;
`ifdef KBD_SHIFT_EN
    if (shift_on_q && asc >= 8'h61 && asc <= 8'h7A) make_ascii = asc - 8'h20;
`endif
  end

  always_comb begin
    dec_st_d = dec_st_q;
    state_d  = state_q;
    ascii_d  = ascii_q;
    held_d   = held_q;
    count_d  = count_q;
`ifdef KBD_SHIFT_EN
    shift_on_d = shift_on_q;
`endif
    // Release pulse lasts one cycle unless the next popped byte overrides it
    if (state_q == 2'b10) begin
      state_d = 2'b00;
      ascii_d = 8'h00;
    end
    if (pop) begin
      unique case (dec_st_q)
        StIdle: begin
          if (pop_byte == CodeBrk) dec_st_d = StBrk;
          else if (pop_byte == CodeExt) dec_st_d = StExt;
`ifdef KBD_SHIFT_EN
          else if (is_shift) shift_on_d = 1'b1;
`endif
          else if (asc != 8'h00 && pop_byte != held_q) begin
            held_d  = pop_byte;
            ascii_d = make_ascii;
            state_d = 2'b01;
            count_d = count_q + 8'd1;
          end
        end
        StBrk: begin
          dec_st_d = StIdle;
`ifdef KBD_SHIFT_EN
          if (is_shift) shift_on_d = 1'b0;
          else
`endif
          if (held_q != 8'h00 && pop_byte == held_q) begin
            state_d = 2'b10;
            held_d  = 8'h00;
          end
        end
        StExt:    dec_st_d = (pop_byte == CodeBrk) ? StExtBrk : StIdle;
        StExtBrk: dec_st_d = StIdle;
        default:  dec_st_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge clrn_ni) begin
    if (!clrn_ni) begin
      dec_st_q <= StIdle;
      state_q  <= 2'b00;
      ascii_q  <= '0;
      held_q   <= '0;
      count_q  <= '0;
`ifdef KBD_SHIFT_EN
      shift_on_q <= 1'b0;
`endif
    end else begin
      dec_st_q <= dec_st_d;
      state_q  <= state_d;
      ascii_q  <= ascii_d;
      held_q   <= held_d;
      count_q  <= count_d;
`ifdef KBD_SHIFT_EN
      shift_on_q <= shift_on_d;
`endif
    end
  end

  assign state_o     = state_q;
  assign kbd_ascii_o = ascii_q;
  assign key_count_o = count_q;
  assign err_o       = err_q;
  assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Bench for ps2_kbd_ascii: directed vector table, multi-cycle corner sequences and a
// randomized byte stream checked against a prefix/held-key reference model.
module tb_ps2_kbd_ascii;
  localparam int unsigned Tmo = 200;
`ifdef KBD_SHIFT_EN
  localparam bit ShiftEn = 1'b1;
`else
  localparam bit ShiftEn = 1'b0;
`endif

  logic clk = 1'b0, clrn_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, stall = 1'b0;
  logic [1:0] state;
  logic [7:0] kbd_ascii, key_count;
  logic err, overflow;

  ps2_kbd_ascii #(.TIMEOUT(Tmo)) dut (
    .clk_i(clk), .clrn_ni(clrn_n), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
    .dbg_stall_i(stall), .state_o(state), .kbd_ascii_o(kbd_ascii), .key_count_o(key_count),
    .err_o(err), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int err_cycles = 0, rel_cycles = 0, dbl10 = 0, st11 = 0;
  int exp_err = 0, exp_rel = 0;
  bit prev10 = 1'b0;

  always @(negedge clk) begin
    if (clrn_n) begin
      if (err) err_cycles++;
      if (state == 2'b10) begin
        rel_cycles++;
        if (prev10) dbl10++;
      end
      if (state == 2'b11) st11++;
      prev10 = (state == 2'b10);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ps2_send(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      #40 ps2_clk = 1'b0;
      #80 ps2_clk = 1'b1;
      #40;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    ps2_send(b, bad, 11);
    repeat (6) @(negedge clk);
  endtask

  // Reference model: scancode tables and held-key bookkeeping
  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                              8'h46};
  logic [7:0] m_held = 8'h00, m_ascii = 8'h00, m_count = 8'h00;
  bit         m_shift = 1'b0;
  logic [7:0] pfx [$];

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit upper);
    for (int i = 0; i < 26; i++) if (letters[i] == c) return (upper ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++) if (digits[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  function automatic bit is_shift_code(input logic [7:0] c);
    return ShiftEn && (c == 8'h12 || c == 8'h59);
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] a;
    if (pfx.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0) pfx.push_back(b);
      else if (is_shift_code(b)) m_shift = 1'b1;
      else begin
        a = ref_ascii(b, m_shift);
        if (a != 8'h00 && b != m_held) begin
          m_held = b;
          m_ascii = a;
          m_count++;
        end
      end
    end else if (pfx[0] == 8'hF0) begin
      if (is_shift_code(b)) m_shift = 1'b0;
      else if (m_held != 8'h00 && b == m_held) begin
        m_held = 8'h00;
        m_ascii = 8'h00;
        exp_rel++;
      end
      pfx.delete();
    end else if (pfx.size() == 1 && b == 8'hF0) pfx.push_back(b);
    else pfx.delete();
  endtask

  task automatic rand_send(input logic [7:0] b);
    bit bad;
    bad = ($urandom_range(0, 9) == 0);
    send_byte(b, bad);
    if (bad) exp_err++;
    else model_byte(b);
    chk("rnd_state", state, (m_held != 8'h00) ? 2'b01 : 2'b00);
    chk("rnd_ascii", kbd_ascii, m_ascii);
    chk("rnd_count", key_count, m_count);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad;
    logic [1:0] st;
    logic [7:0] asc;
    logic [7:0] cnt;
    int         e;
    int         r;
  } vec_t;
  vec_t vecs [$];

  logic [7:0] pool [16] = '{8'h1C, 8'h32, 8'h21, 8'h2A, 8'h1A, 8'h45, 8'h16, 8'h29, 8'h5A,
                            8'h12, 8'h59, 8'h76, 8'h0E, 8'h66, 8'h34, 8'h3B};
  logic [7:0] ovf_codes [9] = '{8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};

  initial begin
    logic [7:0] shifted_a;
    shifted_a = ShiftEn ? 8'h41 : 8'h61;
    vecs.push_back('{8'h1C, 0, 2'b01, 8'h61, 8'd1, 0, 0});
    vecs.push_back('{8'hF0, 0, 2'b01, 8'h61, 8'd1, 0, 0});
    vecs.push_back('{8'h1C, 0, 2'b00, 8'h00, 8'd1, 0, 1});
    vecs.push_back('{8'h1C, 1, 2'b00, 8'h00, 8'd1, 1, 0});
    vecs.push_back('{8'h1C, 0, 2'b01, 8'h61, 8'd2, 0, 0});
    vecs.push_back('{8'h1C, 0, 2'b01, 8'h61, 8'd2, 0, 0});
    vecs.push_back('{8'h1C, 0, 2'b01, 8'h61, 8'd2, 0, 0});
    vecs.push_back('{8'hE0, 0, 2'b01, 8'h61, 8'd2, 0, 0});
    vecs.push_back('{8'h75, 0, 2'b01, 8'h61, 8'd2, 0, 0});
    vecs.push_back('{8'hE0, 0, 2'b01, 8'h61, 8'd2, 0, 0});
    vecs.push_back('{8'hF0, 0, 2'b01, 8'h61, 8'd2, 0, 0});
    vecs.push_back('{8'h75, 0, 2'b01, 8'h61, 8'd2, 0, 0});
    vecs.push_back('{8'h29, 0, 2'b01, 8'h20, 8'd3, 0, 0});
    vecs.push_back('{8'h5A, 0, 2'b01, 8'h0D, 8'd4, 0, 0});
    vecs.push_back('{8'hF0, 0, 2'b01, 8'h0D, 8'd4, 0, 0});
    vecs.push_back('{8'h29, 0, 2'b01, 8'h0D, 8'd4, 0, 0});
    vecs.push_back('{8'h45, 0, 2'b01, 8'h30, 8'd5, 0, 0});
    vecs.push_back('{8'h12, 0, 2'b01, 8'h30, 8'd5, 0, 0});
    vecs.push_back('{8'h1C, 0, 2'b01, shifted_a, 8'd6, 0, 0});
    vecs.push_back('{8'hF0, 0, 2'b01, shifted_a, 8'd6, 0, 0});
    vecs.push_back('{8'h12, 0, 2'b01, shifted_a, 8'd6, 0, 0});
    vecs.push_back('{8'h32, 0, 2'b01, 8'h62, 8'd7, 0, 0});
    vecs.push_back('{8'h76, 0, 2'b01, 8'h62, 8'd7, 0, 0});

    repeat (4) @(negedge clk);
    chk("rst_state", state, 2'b00);
    chk("rst_ascii", kbd_ascii, 8'h00);
    chk("rst_count", key_count, 8'h00);
    chk("rst_err", err, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    clrn_n = 1'b1;
    repeat (4) @(negedge clk);

    foreach (vecs[i]) begin
      send_byte(vecs[i].code, vecs[i].bad);
      exp_err += vecs[i].e;
      exp_rel += vecs[i].r;
      chk($sformatf("vec%0d_state", i), state, vecs[i].st);
      chk($sformatf("vec%0d_ascii", i), kbd_ascii, vecs[i].asc);
      chk($sformatf("vec%0d_count", i), key_count, vecs[i].cnt);
      chk($sformatf("vec%0d_err", i), err_cycles, exp_err);
    end

    // Queued F0 32 1C: release pulse immediately followed by a new make
    stall = 1'b1;
    send_byte(8'hF0, 0);
    send_byte(8'h32, 0);
    send_byte(8'h1C, 0);
    stall = 1'b0;
    @(negedge clk);
    chk("burst_brk_state", state, 2'b01);
    chk("burst_brk_ascii", kbd_ascii, 8'h62);
    @(negedge clk);
    chk("burst_rel_state", state, 2'b10);
    @(negedge clk);
    chk("burst_make_state", state, 2'b01);
    chk("burst_make_ascii", kbd_ascii, 8'h61);
    chk("burst_make_count", key_count, 8'd8);
    exp_rel++;

    // Overflow: nine frames into a stalled FIFO, the ninth is lost
    stall = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(ovf_codes[i], 0);
    chk("ovf_before", overflow, 1'b0);
    send_byte(ovf_codes[8], 0);
    chk("ovf_after", overflow, 1'b1);
    stall = 1'b0;
    repeat (12) @(negedge clk);
    chk("ovf_ascii", kbd_ascii, 8'h69);
    chk("ovf_count", key_count, 8'd16);
    chk("ovf_state", state, 2'b01);
    chk("ovf_sticky", overflow, 1'b1);

    // Timeout on a partial frame
    ps2_send(8'h1C, 0, 6);
    repeat (Tmo + 10) @(negedge clk);
    exp_err++;
    chk("tmo_err", err_cycles, exp_err);
    send_byte(8'h1C, 0);
    chk("tmo_next_ascii", kbd_ascii, 8'h61);
    chk("tmo_next_count", key_count, 8'd17);

    // Reset mid-frame discards the partial frame and clears everything
    ps2_send(8'h32, 0, 6);
    clrn_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_state", state, 2'b00);
    chk("mrst_ascii", kbd_ascii, 8'h00);
    chk("mrst_count", key_count, 8'h00);
    chk("mrst_ovf", overflow, 1'b0);
    clrn_n = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h1C, 0);
    chk("mrst_next_state", state, 2'b01);
    chk("mrst_next_ascii", kbd_ascii, 8'h61);
    chk("mrst_next_count", key_count, 8'd1);
    chk("mrst_next_err", err_cycles, exp_err);

    // Randomized stream against the model, starting from the known held 'a'
    m_held = 8'h1C; m_ascii = 8'h61; m_count = 8'd1; m_shift = 1'b0;
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k <= 4) rand_send(pool[$urandom_range(0, 15)]);
      else if (k <= 6) begin
        rand_send(8'hF0);
        rand_send((m_held != 8'h00 && $urandom_range(0, 2) != 0) ? m_held
                                                                : pool[$urandom_range(0, 15)]);
      end else if (k == 7) begin
        rand_send(8'hE0);
        rand_send(pool[$urandom_range(0, 15)]);
      end else if (k == 8) begin
        rand_send(8'hE0);
        rand_send(8'hF0);
        rand_send(pool[$urandom_range(0, 15)]);
      end else begin
        rand_send(8'hF0);
        rand_send($urandom_range(0, 1) ? 8'h12 : 8'h59);
      end
    end

    repeat (4) @(negedge clk);
    chk("err_pulses", err_cycles, exp_err);
    chk("release_pulses", rel_cycles, exp_rel);
    chk("release_one_cycle", dbl10, 0);
    chk("state_11_never", st11, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
